// File: rtl/video_timing_gen_pkg.sv
// System86 raster timing defaults and the window-decode helper shared by video_timing_gen.
package video_timing_gen_pkg;

    localparam int SYS86_H_TOTAL      = 384;
    localparam int SYS86_H_VISIBLE    = 288;
    localparam int SYS86_H_SYNC_START = 320;
    localparam int SYS86_H_SYNC_WIDTH = 32;
    localparam int SYS86_V_TOTAL      = 264;
    localparam int SYS86_V_VISIBLE    = 224;
    localparam int SYS86_V_SYNC_START = 240;
    localparam int SYS86_V_SYNC_WIDTH = 3;

    // Windows running past the line/frame end simply stop at the last count; nothing wraps.
    function automatic logic in_window(input int pos, input int start, input int width);
        return (pos >= start) && (pos < start + width);
    endfunction

endpackage

// File: rtl/video_timing_gen_mod_counter.sv
// Modulo-N counter with enable; wrap flags the enabled cycle that returns the count to zero.
module mod_counter #(
    parameter int N     = 384,
    parameter int WIDTH = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster and CPU bus-phase timing generator for the System86 board model.
// Define VIDEO_TIMING_COUNTERS_EN to expose the raw counters on HPOS/VPOS.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int H_TOTAL      = SYS86_H_TOTAL,
    parameter int H_VISIBLE    = SYS86_H_VISIBLE,
    parameter int H_SYNC_START = SYS86_H_SYNC_START,
    parameter int H_SYNC_WIDTH = SYS86_H_SYNC_WIDTH,
    parameter int V_TOTAL      = SYS86_V_TOTAL,
    parameter int V_VISIBLE    = SYS86_V_VISIBLE,
    parameter int V_SYNC_START = SYS86_V_SYNC_START,
    parameter int V_SYNC_WIDTH = SYS86_V_SYNC_WIDTH
) (
    input  logic CLK_6M,
    input  logic rst,
    output logic CLK_1H,
    output logic CLK_2H,
    output logic CLK_S1H,
    output logic CLK_S2H,
    output logic nHBLANK,
    output logic nVBLANK,
    output logic nHSYNC,
    output logic nVSYNC,
    output logic LINE_STB,
    output logic FRAME_STB
`ifdef VIDEO_TIMING_COUNTERS_EN
    ,
    output logic [$clog2(H_TOTAL)-1:0] HPOS,
    output logic [$clog2(V_TOTAL)-1:0] VPOS
`endif
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    logic [HW-1:0] hcnt;
    logic [HW-1:0] h_next;
    logic [VW-1:0] vcnt;
    logic [VW-1:0] v_next;
    logic          h_wrap;
    logic          v_wrap;
    int            h_pos;
    int            v_pos;

    mod_counter #(.N(H_TOTAL), .WIDTH(HW)) u_hcnt (
        .clk   (CLK_6M),
        .rst   (rst),
        .en    (1'b1),
        .count (hcnt),
        .wrap  (h_wrap)
    );

    mod_counter #(.N(V_TOTAL), .WIDTH(VW)) u_vcnt (
        .clk   (CLK_6M),
        .rst   (rst),
        .en    (h_wrap),
        .count (vcnt),
        .wrap  (v_wrap)
    );

    // Outputs are decoded from the value the counters are about to load, so they line up with them.
    always_comb begin
        h_next = h_wrap ? '0 : hcnt + 1'b1;
        v_next = vcnt;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vcnt + 1'b1;
        end
        h_pos = int'(h_next);
        v_pos = int'(v_next);
    end

    always_ff @(posedge CLK_6M) begin
        if (rst) begin
            CLK_1H    <= 1'b0;
            CLK_2H    <= 1'b0;
            CLK_S1H   <= 1'b0;
            CLK_S2H   <= 1'b0;
            nHBLANK   <= 1'b1;
            nVBLANK   <= 1'b1;
            nHSYNC    <= 1'b1;
            nVSYNC    <= 1'b1;
            LINE_STB  <= 1'b0;
            FRAME_STB <= 1'b0;
        end else begin
            CLK_1H    <= h_next[0];
            CLK_2H    <= h_next[1];
            CLK_S1H   <= CLK_1H;
            CLK_S2H   <= CLK_2H;
            nHBLANK   <= h_pos < H_VISIBLE;
            nVBLANK   <= v_pos < V_VISIBLE;
            nHSYNC    <= !in_window(h_pos, H_SYNC_START, H_SYNC_WIDTH);
            nVSYNC    <= !in_window(v_pos, V_SYNC_START, V_SYNC_WIDTH);
            LINE_STB  <= h_pos == H_TOTAL - 1;
            FRAME_STB <= (h_pos == H_TOTAL - 1) && (v_pos == V_VISIBLE - 1);
        end
    end

`ifdef VIDEO_TIMING_COUNTERS_EN
    assign HPOS = hcnt;
    assign VPOS = vcnt;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a System86-size instance and a shrunken-raster instance.
module tb_video_timing_gen;

    localparam int A_HT = 384, A_HV = 288, A_HSS = 320, A_HSW = 32;
    localparam int A_VT = 264, A_VV = 224, A_VSS = 240, A_VSW = 3;
    // Small raster: both sync windows run past the end of line/frame and must be cut off there.
    localparam int B_HT = 16, B_HV = 12, B_HSS = 13, B_HSW = 4;
    localparam int B_VT = 10, B_VV = 7, B_VSS = 8, B_VSW = 3;

    typedef struct {
        int         due;
        int         k;
        logic [9:0] exp;
        string      name;
    } chk_t;

    typedef struct {
        int         k;
        logic [9:0] v;
    } lit_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   tick = 0;
    int   n_total = 0;
    int   n_pass = 0;
    chk_t q_a[$];
    chk_t q_b[$];
    chk_t e_a;
    chk_t e_b;

    // {1H, 2H, S1H, S2H, nHBLANK, nVBLANK, nHSYNC, nVSYNC, LINE_STB, FRAME_STB}
    lit_t lit_a [6] = '{
        '{1,   10'b1000111100},
        '{288, 10'b0011011100},
        '{320, 10'b0011010100},
        '{352, 10'b0011011100},
        '{383, 10'b1101011110},
        '{384, 10'b0011111100}
    };
    lit_t lit_b [5] = '{
        '{111, 10'b1101010111},
        '{112, 10'b0011101100},
        '{128, 10'b0011101000},
        '{159, 10'b1101000010},
        '{160, 10'b0011111100}
    };

    logic a_1h, a_2h, a_s1h, a_s2h, a_nhb, a_nvb, a_nhs, a_nvs, a_ls, a_fs;
    logic b_1h, b_2h, b_s1h, b_s2h, b_nhb, b_nvb, b_nhs, b_nvs, b_ls, b_fs;
    logic [9:0] act_a;
    logic [9:0] act_b;
`ifdef VIDEO_TIMING_COUNTERS_EN
    logic [8:0] a_hpos;
    logic [8:0] a_vpos;
    logic [3:0] b_hpos;
    logic [3:0] b_vpos;
`endif

    assign act_a = {a_1h, a_2h, a_s1h, a_s2h, a_nhb, a_nvb, a_nhs, a_nvs, a_ls, a_fs};
    assign act_b = {b_1h, b_2h, b_s1h, b_s2h, b_nhb, b_nvb, b_nhs, b_nvs, b_ls, b_fs};

    video_timing_gen dut_a (
        .CLK_6M    (clk),
        .rst       (rst_a),
        .CLK_1H    (a_1h),
        .CLK_2H    (a_2h),
        .CLK_S1H   (a_s1h),
        .CLK_S2H   (a_s2h),
        .nHBLANK   (a_nhb),
        .nVBLANK   (a_nvb),
        .nHSYNC    (a_nhs),
        .nVSYNC    (a_nvs),
        .LINE_STB  (a_ls),
        .FRAME_STB (a_fs)
`ifdef VIDEO_TIMING_COUNTERS_EN
        ,
        .HPOS      (a_hpos),
        .VPOS      (a_vpos)
`endif
    );

    video_timing_gen #(
        .H_TOTAL(B_HT), .H_VISIBLE(B_HV), .H_SYNC_START(B_HSS), .H_SYNC_WIDTH(B_HSW),
        .V_TOTAL(B_VT), .V_VISIBLE(B_VV), .V_SYNC_START(B_VSS), .V_SYNC_WIDTH(B_VSW)
    ) dut_b (
        .CLK_6M    (clk),
        .rst       (rst_b),
        .CLK_1H    (b_1h),
        .CLK_2H    (b_2h),
        .CLK_S1H   (b_s1h),
        .CLK_S2H   (b_s2h),
        .nHBLANK   (b_nhb),
        .nVBLANK   (b_nvb),
        .nHSYNC    (b_nhs),
        .nVSYNC    (b_nvs),
        .LINE_STB  (b_ls),
        .FRAME_STB (b_fs)
`ifdef VIDEO_TIMING_COUNTERS_EN
        ,
        .HPOS      (b_hpos),
        .VPOS      (b_vpos)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    // k counts cycles since the last edge that sampled reset high; k=0 is the reset state.
    function automatic logic [9:0] expect_vec(input int k, input int ht, input int hv, input int hss,
                                              input int hsw, input int vt, input int vv,
                                              input int vss, input int vsw);
        int   h;
        int   v;
        int   hp;
        logic s1;
        logic s2;
        h = k % ht;
        v = (k / ht) % vt;
        s1 = 1'b0;
        s2 = 1'b0;
        if (k > 0) begin
            hp = (k - 1) % ht;
            s1 = hp[0];
            s2 = hp[1];
        end
        return {h[0], h[1], s1, s2,
                (h < hv) ? 1'b1 : 1'b0,
                (v < vv) ? 1'b1 : 1'b0,
                (h >= hss && h < hss + hsw) ? 1'b0 : 1'b1,
                (v >= vss && v < vss + vsw) ? 1'b0 : 1'b1,
                (h == ht - 1) ? 1'b1 : 1'b0,
                (h == ht - 1 && v == vv - 1) ? 1'b1 : 1'b0};
    endfunction

    function automatic logic [9:0] exp_a(input int k);
        return expect_vec(k, A_HT, A_HV, A_HSS, A_HSW, A_VT, A_VV, A_VSS, A_VSW);
    endfunction

    function automatic logic [9:0] exp_b(input int k);
        return expect_vec(k, B_HT, B_HV, B_HSS, B_HSW, B_VT, B_VV, B_VSS, B_VSW);
    endfunction

    task automatic push_a(input int due, input int k, input logic [9:0] exp, input string name);
        chk_t c;
        c.due = due;
        c.k = k;
        c.exp = exp;
        c.name = name;
        q_a.push_back(c);
    endtask

    task automatic push_b(input int due, input int k, input logic [9:0] exp, input string name);
        chk_t c;
        c.due = due;
        c.k = k;
        c.exp = exp;
        c.name = name;
        q_b.push_back(c);
    endtask

    task automatic check_output(input string name, input int due, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (due != tick) begin
            $display("[TB] FAIL %s k=%0d checked at tick %0d, required at tick %0d", name, k, tick, due);
        end else if (act !== exp) begin
            $display("[TB] FAIL %s k=%0d got=%b want=%b", name, k, act[9:0], exp[9:0]);
        end else begin
            n_pass++;
        end
    endtask

    always @(negedge clk) begin
        while (q_a.size() > 0 && q_a[0].due <= tick) begin
            e_a = q_a.pop_front();
            check_output({"A.", e_a.name}, e_a.due, e_a.k, {22'b0, act_a}, {22'b0, e_a.exp});
`ifdef VIDEO_TIMING_COUNTERS_EN
            check_output("A.hpos", e_a.due, e_a.k, 32'(a_hpos), 32'(e_a.k % A_HT));
            check_output("A.vpos", e_a.due, e_a.k, 32'(a_vpos), 32'((e_a.k / A_HT) % A_VT));
`endif
        end
        while (q_b.size() > 0 && q_b[0].due <= tick) begin
            e_b = q_b.pop_front();
            check_output({"B.", e_b.name}, e_b.due, e_b.k, {22'b0, act_b}, {22'b0, e_b.exp});
`ifdef VIDEO_TIMING_COUNTERS_EN
            check_output("B.hpos", e_b.due, e_b.k, 32'(b_hpos), 32'(e_b.k % B_HT));
            check_output("B.vpos", e_b.due, e_b.k, 32'(b_vpos), 32'((e_b.k / B_HT) % B_VT));
`endif
        end
    end

    task automatic apply_stimulus_a();
        int r;
        repeat (2) @(negedge clk);
        push_a(tick + 1, 0, 10'b0000111100, "reset_state");
        @(negedge clk);
        r = tick;
        rst_a = 1'b0;
        for (int k = 1; k <= 2 * A_HT + 16; k++) begin
            push_a(r + k, k, exp_a(k), "sweep");
            foreach (lit_a[i]) begin
                if (lit_a[i].k == k) push_a(r + k, k, lit_a[i].v, "vector");
            end
        end
        push_a(r + 38600, 38600, 10'b0011111100, "midframe");
        while (tick < r + 38600) @(negedge clk);
        rst_a = 1'b1;
        for (int i = 1; i <= 3; i++) push_a(tick + i, 0, 10'b0000111100, "reset_hold");
        repeat (3) @(negedge clk);
        r = tick;
        rst_a = 1'b0;
        for (int k = 1; k <= 8; k++) push_a(r + k, k, exp_a(k), "post_reset");
        repeat (10) @(negedge clk);
    endtask

    task automatic apply_stimulus_b();
        int r;
        // Held in reset past the point where the first frame strobe would otherwise land.
        for (int i = 1; i <= 120; i++) push_b(tick + i, 0, 10'b0000111100, "reset_hold");
        repeat (120) @(negedge clk);
        r = tick;
        rst_b = 1'b0;
        for (int k = 1; k <= 2 * B_HT * B_VT + 5 * B_HT + 7; k++) begin
            push_b(r + k, k, exp_b(k), "sweep");
            foreach (lit_b[i]) begin
                if (lit_b[i].k == k) push_b(r + k, k, lit_b[i].v, "vector");
            end
        end
        repeat (2 * B_HT * B_VT + 5 * B_HT + 7) @(negedge clk);
        rst_b = 1'b1;
        for (int i = 1; i <= 3; i++) push_b(tick + i, 0, 10'b0000111100, "mid_reset");
        repeat (3) @(negedge clk);
        r = tick;
        rst_b = 1'b0;
        for (int k = 1; k <= 20; k++) push_b(r + k, k, exp_b(k), "post_reset");
        repeat (24) @(negedge clk);
    endtask

    initial begin
        fork
            apply_stimulus_a();
            apply_stimulus_b();
        join
        repeat (2) @(negedge clk);
        while (q_a.size() > 0) begin
            e_a = q_a.pop_front();
            n_total++;
            $display("[TB] FAIL A.%s k=%0d never checked, due tick %0d", e_a.name, e_a.k, e_a.due);
        end
        while (q_b.size() > 0) begin
            e_b = q_b.pop_front();
            n_total++;
            $display("[TB] FAIL B.%s k=%0d never checked, due tick %0d", e_b.name, e_b.k, e_b.due);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: tick=%0d passed=%0d total=%0d", tick, n_pass, n_total);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
